// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared sizes and scan state encoding for the sensor scanner
package temp_pkg;
    localparam int NUM_SENSORS = 5;
    localparam int SENSOR_W    = 8;
    localparam int FRAME_W     = 40;
    localparam int SEL_W       = 3;

    typedef enum logic [1:0] {
        IDLE,
        POLL,
        GAP,
        DONE
    } scan_state_t;
endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - saturating per-sensor POLL cycle counter with timeout flag
module scan_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            count <= '0;
        end else if (enable && count != CW'(TIMEOUT_CYC)) begin
            count <= count + 1'b1;
        end
    end

    // count holds completed POLL cycles, so the current cycle is the last one allowed
    assign expired = enable && (count == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/sensor_scanner.sv
// rtl/sensor_scanner.sv - polls five temperature sensors into a frame; RANGE_CHECK_EN rejects hot readings
module sensor_scanner
    import temp_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
`ifdef RANGE_CHECK_EN
    ,
    parameter int MAX_TEMP_C  = 125
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic [SEL_W-1:0]       sens_sel_o,
    output logic                   sens_req_o,
    input  logic                   sens_ack_i,
    input  logic [SENSOR_W-1:0]    sens_data_i,
    output logic [FRAME_W-1:0]     sensors_data_o,
    output logic [NUM_SENSORS-1:0] sensors_en_o,
    output logic                   frame_valid_o,
    output logic                   busy_o
);
    scan_state_t state, state_nxt;
    logic [FRAME_W-1:0]     shadow_data;
    logic [NUM_SENSORS-1:0] shadow_en;
    logic                   expired;
    logic                   accept;
    logic                   last_sensor;

`ifdef RANGE_CHECK_EN
    assign accept = (sens_data_i <= SENSOR_W'(MAX_TEMP_C));
`else
    assign accept = 1'b1;
`endif

    assign last_sensor = (sens_sel_o == SEL_W'(NUM_SENSORS - 1));

    scan_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (state != POLL),
        .enable (state == POLL),
        .expired(expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = POLL;
            POLL: if (sens_ack_i || expired) state_nxt = GAP;
            GAP:  state_nxt = last_sensor ? DONE : POLL;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sens_req_o    = (state == POLL);
    assign busy_o        = (state != IDLE);
    assign frame_valid_o = (state == DONE);

    // Published outputs load on the GAP->DONE edge so DONE already shows the new frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sens_sel_o     <= '0;
            shadow_data    <= '0;
            shadow_en      <= '0;
            sensors_data_o <= '0;
            sensors_en_o   <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) sens_sel_o <= '0;
                POLL: begin
                    if (sens_ack_i) begin
                        shadow_data[sens_sel_o*SENSOR_W +: SENSOR_W] <= accept ? sens_data_i : '0;
                        shadow_en[sens_sel_o] <= accept;
                    end else if (expired) begin
                        shadow_data[sens_sel_o*SENSOR_W +: SENSOR_W] <= '0;
                        shadow_en[sens_sel_o] <= 1'b0;
                    end
                end
                GAP: begin
                    if (last_sensor) begin
                        sensors_data_o <= shadow_data;
                        sensors_en_o   <= shadow_en;
                    end else begin
                        sens_sel_o <= sens_sel_o + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
